// File: rtl/regfile_pkg.sv
// Shared widths, requester ids and write payload type for the register file
// and its write-port arbiter.
package regfile_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_MEM = 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    // Round-robin pointer: which requester wins the next tie
    typedef enum logic {
        PRI_ALU = 1'b0,
        PRI_MEM = 1'b1
    } rr_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational, the priority pointer
// flips to the other requester after every grant.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    rr_t rr;
    rr_t rr_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= PRI_ALU;
        end else begin
            rr <= rr_next;
        end
    end

    always_comb begin
        gnt     = 2'b00;
        rr_next = rr;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (rr == PRI_ALU) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
        // Loser of this grant gets priority next time
        if (gnt[REQ_ALU]) begin
            rr_next = PRI_MEM;
        end else if (gnt[REQ_MEM]) begin
            rr_next = PRI_ALU;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register file write port between ALU and load writeback, with a
// registered output stage and read-port forward-hit flags.
module regfile_wr_arbiter
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] read_1,
    input  logic [ADDR_W-1:0] read_2,
    output logic              regWrite,
    output logic [ADDR_W-1:0] write,
    output logic [DATA_W-1:0] write_data,
    output logic              fwd_1_hit,
    output logic              fwd_2_hit
);

    logic [1:0] gnt;
    logic       arb_en;
    wr_req_t    sel;

    assign arb_en = !stall && !rst;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (arb_en),
        .req ({req1_valid, req0_valid}),
        .gnt (gnt)
    );

    assign req0_ready = gnt[REQ_ALU];
    assign req1_ready = gnt[REQ_MEM];

    always_comb begin
        sel.addr = req0_addr;
        sel.data = req0_data;
        if (gnt[REQ_MEM]) begin
            sel.addr = req1_addr;
            sel.data = req1_data;
        end
    end

    // Address/data hold when idle; writes to x0 are accepted but suppressed
    always_ff @(posedge clk) begin
        if (rst) begin
            regWrite   <= 1'b0;
            write      <= '0;
            write_data <= '0;
        end else if (|gnt) begin
            regWrite   <= (sel.addr != '0);
            write      <= sel.addr;
            write_data <= sel.data;
        end else begin
            regWrite   <= 1'b0;
        end
    end

    assign fwd_1_hit = regWrite && (write == read_1) && (read_1 != '0);
    assign fwd_2_hit = regWrite && (write == read_2) && (read_2 != '0);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: per-cycle model comparison plus
// hand-computed literal expectations.
module tb_regfile_wr_arbiter;
    import regfile_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall;
    logic              req0_valid, req1_valid;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic [DATA_W-1:0] req0_data, req1_data;
    logic              req0_ready, req1_ready;
    logic [ADDR_W-1:0] read_1, read_2;
    logic              regWrite;
    logic [ADDR_W-1:0] write;
    logic [DATA_W-1:0] write_data;
    logic              fwd_1_hit, fwd_2_hit;

    int checks = 0;
    int errors = 0;

    regfile_wr_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .read_1     (read_1),
        .read_2     (read_2),
        .regWrite   (regWrite),
        .write      (write),
        .write_data (write_data),
        .fwd_1_hit  (fwd_1_hit),
        .fwd_2_hit  (fwd_2_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: who wins, what the write port shows next, register contents
    int          m_pri;
    logic        m_init = 1'b0;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [31:0] regs [32];

    always @(negedge clk) begin
        int winner;
        winner = -1;
        if (!rst && !stall) begin
            if (req0_valid && req1_valid) winner = m_pri;
            else if (req0_valid)          winner = 0;
            else if (req1_valid)          winner = 1;
        end
        check("ready0", 32'(req0_ready), 32'(winner == 0));
        check("ready1", 32'(req1_ready), 32'(winner == 1));
        if (m_init) begin
            check("regWrite", 32'(regWrite), 32'(m_we));
            check("write", 32'(write), 32'(m_waddr));
            check("write_data", write_data, m_wdata);
            check("fwd_1", 32'(fwd_1_hit), 32'(m_we && m_waddr == read_1 && read_1 != 0));
            check("fwd_2", 32'(fwd_2_hit), 32'(m_we && m_waddr == read_2 && read_2 != 0));
            if (m_we && m_waddr != 0) regs[m_waddr] = m_wdata;
        end
        if (rst) begin
            m_init  = 1'b1;
            m_we    = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
            m_pri   = 0;
        end else if (winner >= 0) begin
            m_waddr = (winner == 0) ? req0_addr : req1_addr;
            m_wdata = (winner == 0) ? req0_data : req1_data;
            m_we    = (m_waddr != 0);
            m_pri   = 1 - winner;
        end else begin
            m_we = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] exp_seq [4];
        exp_seq = '{5'd1, 5'd2, 5'd1, 5'd2};
        foreach (regs[i]) regs[i] = '0;
        rst = 1'b1; stall = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h33;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h44;
        read_1 = '0; read_2 = '0;

        // Reset with both requesters valid
        @(negedge clk);
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        check("rst_regWrite", 32'(regWrite), 32'd0);
        check("rst_write", 32'(write), 32'd0);
        check("rst_write_data", write_data, 32'd0);
        step();

        // Single ALU request to x23
        rst = 1'b0; req1_valid = 1'b0;
        req0_addr = 5'b10111; req0_data = 32'd15;
        @(negedge clk);
        check("single_ready0", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        check("single_regWrite", 32'(regWrite), 32'd1);
        check("single_write", 32'(write), 32'd23);
        check("single_data", write_data, 32'd15);
        step();
        read_1 = 5'd23;
        step();
        check("model_x23", regs[23], 32'd15);
        read_1 = '0;

        // Contention right after reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'hA;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'hB;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("contend_ready0", 32'(req0_ready), 32'(i % 2 == 0));
            @(posedge clk);
            #1;
            check("contend_write", 32'(write), 32'(exp_seq[i]));
        end

        // Write to x0 is accepted but suppressed
        req0_valid = 1'b0;
        req1_addr = 5'd0; req1_data = 32'hDEAD;
        @(negedge clk);
        check("x0_ready1", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 1'b0;
        check("x0_regWrite", 32'(regWrite), 32'd0);
        check("model_x0", regs[0], 32'd0);

        // Forwarding from the output stage
        req0_valid = 1'b1; req0_addr = 5'd21; req0_data = 32'd7;
        read_1 = 5'd21; read_2 = 5'd31;
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        check("fwd1_hit", 32'(fwd_1_hit), 32'd1);
        check("fwd2_miss", 32'(fwd_2_hit), 32'd0);
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h5;
        read_1 = 5'd0;
        step();
        req1_valid = 1'b0;
        @(negedge clk);
        check("fwd_x0_miss", 32'(fwd_1_hit), 32'd0);

        // Give req1 the pointer, then stall with both valid
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
        step();
        stall = 1'b1;
        req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 32'h100;
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_ready0", 32'(req0_ready), 32'd0);
            check("stall_ready1", 32'(req1_ready), 32'd0);
            check("stall_regWrite", 32'(regWrite), 32'd0);
            step();
        end
        stall = 1'b0;
        @(negedge clk);
        check("resume_ready1", 32'(req1_ready), 32'd1);
        step();
        @(negedge clk);
        check("resume_ready0", 32'(req0_ready), 32'd1);
        step();
        check("pre_rst_regWrite", 32'(regWrite), 32'd1);

        // Reset while a write is on the port; pointer returns to req0
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready1", 32'(req1_ready), 32'd0);
        step();
        check("midrst_regWrite", 32'(regWrite), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready0", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
